// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default reset PC, and the opcode/func field positions also used by the
// controller.
package instr_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } if_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned FUNC_MSB = 5;
  localparam int unsigned FUNC_LSB = 0;

  function automatic logic [5:0] op_field(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [5:0] func_field(input logic [31:0] instr);
    return instr[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry prefetch buffer: valid bit plus 64-bit payload
// ({pc_plus4, instr}). Reset and flush both empty it.
module if_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic        unload,
  output logic        valid,
  output logic [63:0] data
);

  // Occupancy and payload; load and unload are never requested together.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: FETCH/VALID FSM holding one instruction for
// the decode stage. Optional feature macro IF_PREFETCH_EN adds a
// one-entry prefetch buffer (if_skid_buf) for 1 instruction/cycle.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = instr_fetch_pkg::RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] Instr,
  output logic [5:0]  Op,
  output logic [5:0]  func,
  output logic [31:0] PCPlus4,
  output logic        InstrValid
);

  import instr_fetch_pkg::*;

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] redirect_pc;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        instr_valid_q;
  logic        unused_redirect_lsbs;

  assign pc_next              = pc + PC_STEP;
  assign redirect_pc          = {RedirectPC[31:2], 2'b00};
  assign unused_redirect_lsbs = ^RedirectPC[1:0];

  assign IMemAddr   = pc;
  assign Instr      = instr_q;
  assign Op         = op_field(instr_q);
  assign func       = func_field(instr_q);
  assign PCPlus4    = pc_plus4_q;
  assign InstrValid = instr_valid_q;

`ifdef IF_PREFETCH_EN

  logic        buf_valid;
  logic [63:0] buf_data;
  logic        buf_load;
  logic        buf_unload;

  // Keep requesting while there is somewhere to put the returned word.
  assign IMemReq = (state == FETCH) || !buf_valid;

  // A stalled ack goes into the buffer; a consume drains it into Instr.
  always_comb begin
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    if (!Rst && !Redirect && state == VALID) begin
      buf_load   = !buf_valid && IMemAck && Stall;
      buf_unload = buf_valid && !Stall;
    end
  end

  if_skid_buf u_skid_buf (
    .clk       (Clk),
    .rst       (Rst),
    .flush     (Redirect),
    .load      (buf_load),
    .load_data ({pc_next, IMemData}),
    .unload    (buf_unload),
    .valid     (buf_valid),
    .data      (buf_data)
  );

  // Fetch FSM with prefetch: VALID keeps fetching while the buffer is free.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= FETCH;
      pc            <= {RESET_PC[31:2], 2'b00};
      instr_q       <= '0;
      pc_plus4_q    <= '0;
      instr_valid_q <= 1'b0;
    end else if (Redirect) begin
      state         <= FETCH;
      pc            <= redirect_pc;
      instr_valid_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (IMemAck) begin
            instr_q       <= IMemData;
            pc_plus4_q    <= pc_next;
            pc            <= pc_next;
            instr_valid_q <= 1'b1;
            state         <= VALID;
          end
        end
        VALID: begin
          if (buf_valid) begin
            if (!Stall) begin
              instr_q    <= buf_data[31:0];
              pc_plus4_q <= buf_data[63:32];
            end
          end else if (IMemAck) begin
            pc <= pc_next;
            if (!Stall) begin
              instr_q    <= IMemData;
              pc_plus4_q <= pc_next;
            end
          end else if (!Stall) begin
            instr_valid_q <= 1'b0;
            state         <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`else

  // Single outstanding request: only FETCH asks memory for a word.
  assign IMemReq = (state == FETCH);

  // Fetch FSM: FETCH waits for ack, VALID waits for decode to consume.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= FETCH;
      pc            <= {RESET_PC[31:2], 2'b00};
      instr_q       <= '0;
      pc_plus4_q    <= '0;
      instr_valid_q <= 1'b0;
    end else if (Redirect) begin
      state         <= FETCH;
      pc            <= redirect_pc;
      instr_valid_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (IMemAck) begin
            instr_q       <= IMemData;
            pc_plus4_q    <= pc_next;
            pc            <= pc_next;
            instr_valid_q <= 1'b1;
            state         <= VALID;
          end
        end
        VALID: begin
          if (!Stall) begin
            instr_valid_q <= 1'b0;
            state         <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table (default
// build), hand-written corner sequences and randomized stimulus against
// a queue-based reference model. Honors IF_PREFETCH_EN.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IF_PREFETCH_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, imem_ack, stall, redirect;
  logic [31:0] imem_data, redirect_pc;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_plus4;
  logic [5:0]  op, func;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .IMemReq    (imem_req),
    .IMemAddr   (imem_addr),
    .IMemAck    (imem_ack),
    .IMemData   (imem_data),
    .Stall      (stall),
    .Redirect   (redirect),
    .RedirectPC (redirect_pc),
    .Instr      (instr),
    .Op         (op),
    .func       (func),
    .PCPlus4    (pc_plus4),
    .InstrValid (instr_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of held instructions -------
  // Front entry is what decode sees; capacity 1 (or 2 with prefetch).
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;

  task automatic step(input bit r, input bit rd, input logic [31:0] rp,
                      input bit a, input bit s, input logic [31:0] d,
                      input bit do_chk);
    bit   req_m, cons, got;
    ent_t w;
    logic [31:0] fi;
    rst = r; redirect = rd; redirect_pc = rp;
    imem_ack = a; stall = s; imem_data = d;
    @(negedge clk);
    req_m = (q.size() < CAP);
    if (do_chk) begin
      chk("req", {31'd0, imem_req}, {31'd0, req_m});
      if (req_m) chk("addr", imem_addr, m_pc);
      chk("valid", {31'd0, instr_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
        fi = q[0].instr;
        chk("instr", instr, fi);
        chk("op", {26'd0, op}, {26'd0, fi[31:26]});
        chk("func", {26'd0, func}, {26'd0, fi[5:0]});
        chk("pc4", pc_plus4, q[0].pc4);
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = RST_PC;
      q.delete();
    end else if (rd) begin
      m_pc = rp & 32'hFFFF_FFFC;
      q.delete();
    end else begin
      cons = (q.size() > 0) && !s;
      got  = req_m && a;
      w.instr = d;
      w.pc4   = m_pc + 32'd4;
      if (got) m_pc = m_pc + 32'd4;
      if (cons) void'(q.pop_front());
      if (got) q.push_back(w);
    end
  endtask

`ifndef IF_PREFETCH_EN
  // ---------------- directed vector table (single-request build) --------
  typedef struct {
    bit          rst, rd;
    logic [31:0] rp;
    bit          ack, stall;
    logic [31:0] data;
    bit          chk_en;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_instr, e_pc4;
  } vec_t;

  vec_t vecs[$];

  task automatic run_table();
    logic [31:0] ei;
    //               rst rd rp            ack st data          chk req addr          vld instr         pc4
    vecs.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0});
    vecs.push_back('{0, 0, 32'h0,        1, 1, 32'h0000_0020, 1, 1, 32'h0,        0, 32'h0,        32'h0});
    vecs.push_back('{0, 0, 32'h0,        0, 1, 32'h0,        1, 0, 32'h0,        1, 32'h0000_0020, 32'h4});
    vecs.push_back('{0, 0, 32'h0,        0, 1, 32'h0,        1, 0, 32'h0,        1, 32'h0000_0020, 32'h4});
    vecs.push_back('{0, 0, 32'h0,        0, 1, 32'h0,        1, 0, 32'h0,        1, 32'h0000_0020, 32'h4});
    vecs.push_back('{0, 0, 32'h0,        1, 0, 32'hDEAD_BEEF, 1, 0, 32'h0,        1, 32'h0000_0020, 32'h4});
    vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h4,        0, 32'h0000_0020, 32'h4});
    vecs.push_back('{0, 1, 32'h0000_0043, 1, 0, 32'hAAAA_0001, 1, 1, 32'h4,        0, 32'h0000_0020, 32'h4});
    vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h40,       0, 32'h0000_0020, 32'h4});
    vecs.push_back('{0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,        1, 1, 32'h40,       0, 32'h0000_0020, 32'h4});
    vecs.push_back('{0, 0, 32'h0,        1, 1, 32'h8C01_0004, 1, 1, 32'hFFFF_FFFC, 0, 32'h0000_0020, 32'h4});
    vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8C01_0004, 32'h0});
    vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h8C01_0004, 32'h0});
    vecs.push_back('{0, 1, 32'h0000_0100, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h8C01_0004, 32'h0});
    vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h100,      0, 32'h8C01_0004, 32'h0});
    vecs.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h100,      0, 32'h8C01_0004, 32'h0});
    vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0});
    vecs.push_back('{0, 0, 32'h0,        1, 1, 32'h0123_4567, 1, 1, 32'h0,        0, 32'h0,        32'h0});
    vecs.push_back('{0, 0, 32'h0,        0, 1, 32'h0,        1, 0, 32'h0,        1, 32'h0123_4567, 32'h4});
    foreach (vecs[i]) begin
      rst = vecs[i].rst; redirect = vecs[i].rd; redirect_pc = vecs[i].rp;
      imem_ack = vecs[i].ack; stall = vecs[i].stall; imem_data = vecs[i].data;
      @(negedge clk);
      if (vecs[i].chk_en) begin
        ei = vecs[i].e_instr;
        chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
        if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
        chk($sformatf("v%0d_instr", i), instr, ei);
        chk($sformatf("v%0d_op", i), {26'd0, op}, {26'd0, ei[31:26]});
        chk($sformatf("v%0d_func", i), {26'd0, func}, {26'd0, ei[5:0]});
        chk($sformatf("v%0d_pc4", i), pc_plus4, vecs[i].e_pc4);
      end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; stall = 1'b0; imem_data = '0;
    repeat (2) @(posedge clk);
    #1;

`ifndef IF_PREFETCH_EN
    run_table();
`endif

    // Sync model with a reset, then reset overriding a same-cycle redirect.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h1111_1111, 1);
    step(1, 1, 32'h0000_0080, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Zero-wait streaming with a one-cycle stall in the middle.
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 1, (i == 4), 32'h0400_0000 + i, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Wrap of the PC at the top of the address space.
    step(0, 1, 32'hFFFF_FFFD, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 32'h2222_0022, 1);
    step(0, 0, 0, 1, 0, 32'h3333_0033, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(63) == 0), ($urandom_range(15) == 0), $urandom,
           $urandom_range(1), ($urandom_range(2) == 0), $urandom, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
